aq_djpeg_bitfeed: RTL and testbench
===================================

AQ_DJPEG_BITFEED -- requirements
Module: aq_djpeg_bitfeed

Interface
REQ-001 SHALL have ports, one per line: name, direction, width, meaning; clock and reset first.
- rst  in  1  asynchronous active-low reset.
- clk  in  1  single clock.
- ProcessInit  in  1  synchronous restart of all state.
- DataInEnable  in  1  entropy-coded byte valid.
- DataIn  in  8  entropy-coded byte.
- DataInRead  out  1  byte accepted this cycle (ready).
- DecodeUseBit  in  1  decoder consumes bits.
- DecodeUseWidth  in  7  bits consumed, legal 1..32.
- DecodeAlignByte  in  1  discard bits up to next byte boundary.
- DataOutEnable  out  1  window valid.
- DataOut  out  32  bit window, MSB = next bit.
- MarkerDetect  out  1  non-RST marker found; feed frozen.
- MarkerCode  out  8  second byte of detected marker.
- RestartCount  out  3  low 3 bits of last RSTn seen.
- StreamError  out  1  sticky illegal-consume flag.
REQ-002 SHALL use one clock domain; reset asynchronous, active-low.

Function
REQ-003 SHALL hold a 64-bit MSB-aligned shift buffer and a 7-bit BitCount (0..64).
REQ-004 DataOut SHALL equal buffer[63:32]; unfilled bits read 0.
REQ-005 DataInRead SHALL be DataInEnable & (BitCount <= 56 after same-cycle consume) & ~MarkerDetect & ~ProcessInit.
REQ-006 Byte handling state machine: IDLE, GOTFF, HOLD.
- IDLE, byte != FF: append at bit position 63-BitCount; BitCount += 8.
- IDLE, byte == FF: go GOTFF, append nothing.
- GOTFF, 00: append FF, go IDLE.
- GOTFF, FF: fill byte, discard, stay GOTFF.
- GOTFF, D0..D7: discard; RestartCount <= byte[2:0]; go IDLE.
- GOTFF, any other: MarkerCode <= byte; MarkerDetect <= 1; go HOLD.
- HOLD: no bytes accepted; exits only via ProcessInit or reset.
REQ-007 DataOutEnable SHALL be (BitCount >= 32) | MarkerDetect; in HOLD zeros are shifted in.
REQ-008 Consume: when DecodeUseBit, buffer shifts left by DecodeUseWidth and BitCount decrements by it, effective next clock edge.
REQ-009 Consume with DecodeUseWidth = 0 or > 32 SHALL clamp to 32 and set StreamError.
REQ-010 Consume with width > BitCount and ~MarkerDetect SHALL set StreamError; BitCount saturates at 0.
REQ-011 Consume in HOLD with width > BitCount SHALL leave BitCount 0 and not set StreamError.
REQ-012 DecodeAlignByte SHALL discard BitCount mod 8 bits.
REQ-013 DecodeAlignByte when BitCount mod 8 = 0 SHALL be a no-op.
REQ-014 Same-cycle consume and byte append: consume applies first, byte lands at the post-consume position.
- Result: BitCount_next = BitCount - W + 8.
REQ-015 DecodeUseBit and DecodeAlignByte together: DecodeUseBit applied first, then alignment on the result.
REQ-016 Combined per-cycle latency: accepted byte visible on DataOut the next cycle.
REQ-017 Combined per-cycle latency: consume reflected on DataOut the next cycle.
REQ-018 ProcessInit SHALL have priority over all same-cycle events.

Reset
REQ-019 On rst low, or ProcessInit high at a clock edge:
- buffer = 0, BitCount = 0, state = IDLE.
- DataOutEnable = 0, DataOut = 0, DataInRead = 0.
- MarkerDetect = 0, MarkerCode = 00, RestartCount = 0, StreamError = 0.
REQ-020 Reset mid-byte or in GOTFF SHALL discard the pending FF.

Verification
REQ-021 Fill: bytes 12 34 56 78 -> after 4th acceptance, DataOut = 12345678, DataOutEnable = 1, BitCount = 32.
REQ-022 Stuffing: bytes AB FF 00 CD EF -> DataOut = ABFFCDEF; FF FF 00 -> single FF appended.
REQ-023 Consume/align:
- Full buffer 12345678 9A..., UseBit width 4 -> DataOut = 23456789.
- Then DecodeAlignByte -> DataOut = 3456789A.
REQ-024 Restart marker: bytes 11 FF D3 22 33 44 -> DataOut = 11223344, RestartCount = 3.
REQ-025 EOI:
- Bytes AA FF D9 -> MarkerDetect = 1, MarkerCode = D9, DataInRead stays 0.
- DataOut = AA000000, DataOutEnable = 1.
REQ-026 Error/reset:
- BitCount 8, consume width 16 -> StreamError = 1.
- ProcessInit -> all outputs return to REQ-019 values next cycle.

Source files
------------

// File: rtl/aq_djpeg_bitfeed.sv
// ---------------------------------------------------------------------------
// aq_djpeg_bitfeed
// Feeds entropy-coded JPEG bytes into a 64-bit MSB-aligned bit window for a
// Huffman decoder. Removes FF00 byte stuffing, swallows FF fill bytes and
// RSTn markers, and freezes the feed when any other marker is found.
//
// Ports
//   rst              async active-low reset
//   clk              clock
//   ProcessInit      synchronous restart of all state (highest priority)
//   DataInEnable     input byte valid
//   DataIn[7:0]      input byte
//   DataInRead       byte accepted this cycle (combinational ready)
//   DecodeUseBit     decoder consumes DecodeUseWidth bits this cycle
//   DecodeUseWidth   bits consumed, legal 1..32 (others clamp to 32 + error)
//   DecodeAlignByte  discard bits up to the next byte boundary
//   DataOutEnable    window valid (>= 32 bits buffered, or marker frozen)
//   DataOut[31:0]    bit window, MSB is the next bit
//   MarkerDetect     non-RST marker found; feed frozen
//   MarkerCode[7:0]  second byte of that marker
//   RestartCount[2:0] low 3 bits of last RSTn seen
//   StreamError      sticky illegal-consume flag
// ---------------------------------------------------------------------------
module aq_djpeg_bitfeed (
  input  logic        rst,
  input  logic        clk,
  input  logic        ProcessInit,
  input  logic        DataInEnable,
  input  logic [7:0]  DataIn,
  output logic        DataInRead,
  input  logic        DecodeUseBit,
  input  logic [6:0]  DecodeUseWidth,
  input  logic        DecodeAlignByte,
  output logic        DataOutEnable,
  output logic [31:0] DataOut,
  output logic        MarkerDetect,
  output logic [7:0]  MarkerCode,
  output logic [2:0]  RestartCount,
  output logic        StreamError
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOTFF = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_r;
  logic [63:0] buf_r;
  logic [6:0]  cnt_r;
  logic        marker_r;
  logic [7:0]  code_r;
  logic [2:0]  rst_cnt_r;
  logic        err_r;

  logic [6:0]  w_s;
  logic        clamp_s;
  logic        under_s;
  logic [63:0] buf_c_s;
  logic [6:0]  cnt_c_s;
  logic [2:0]  align_s;
  logic [63:0] buf_a_s;
  logic [6:0]  cnt_a_s;
  logic        accept_s;
  logic        append_s;
  logic [7:0]  app_byte_s;
  logic [63:0] buf_n_s;
  logic [6:0]  cnt_n_s;
  logic        err_set_s;

  // Next-state datapath: consume, then align, then append at the new tail.
  always_comb begin
    // width clamp
    if ((DecodeUseWidth == 7'd0) || (DecodeUseWidth > 7'd32)) begin
      w_s     = 7'd32;
      clamp_s = 1'b1;
    end else begin
      w_s     = DecodeUseWidth;
      clamp_s = 1'b0;
    end

    // consume: shifting always pulls zeros in; count saturates at 0
    under_s = 1'b0;
    if (DecodeUseBit) begin
      buf_c_s = buf_r << w_s;
      if (w_s > cnt_r) begin
        cnt_c_s = 7'd0;
        under_s = 1'b1;
      end else begin
        cnt_c_s = cnt_r - w_s;
      end
    end else begin
      buf_c_s = buf_r;
      cnt_c_s = cnt_r;
    end

    // align on the post-consume count; mod 8 == 0 shifts by zero
    if (DecodeAlignByte) begin
      align_s = cnt_c_s[2:0];
    end else begin
      align_s = 3'd0;
    end
    buf_a_s = buf_c_s << align_s;
    cnt_a_s = cnt_c_s - {4'd0, align_s};

    accept_s = DataInEnable && (cnt_a_s <= 7'd56) && !marker_r && !ProcessInit;

    // decide whether the accepted byte contributes data
    append_s   = 1'b0;
    app_byte_s = DataIn;
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          append_s = (DataIn != 8'hFF);
        end
        ST_GOTFF: begin
          if (DataIn == 8'h00) begin
            append_s   = 1'b1;
            app_byte_s = 8'hFF;
          end else begin
            append_s = 1'b0;
          end
        end
        default: begin
          append_s = 1'b0;
        end
      endcase
    end else begin
      append_s = 1'b0;
    end

    if (append_s) begin
      buf_n_s = buf_a_s | ({app_byte_s, 56'd0} >> cnt_a_s);
      cnt_n_s = cnt_a_s + 7'd8;
    end else begin
      buf_n_s = buf_a_s;
      cnt_n_s = cnt_a_s;
    end

    // underflow is legal once frozen on a marker (decoder drains zeros)
    err_set_s = DecodeUseBit && (clamp_s || (under_s && !marker_r));
  end

  // Buffer, count, byte FSM and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      buf_r     <= 64'd0;
      cnt_r     <= 7'd0;
      marker_r  <= 1'b0;
      code_r    <= 8'h00;
      rst_cnt_r <= 3'd0;
      err_r     <= 1'b0;
    end else if (ProcessInit) begin
      state_r   <= ST_IDLE;
      buf_r     <= 64'd0;
      cnt_r     <= 7'd0;
      marker_r  <= 1'b0;
      code_r    <= 8'h00;
      rst_cnt_r <= 3'd0;
      err_r     <= 1'b0;
    end else begin
      buf_r <= buf_n_s;
      cnt_r <= cnt_n_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
      if (accept_s) begin
        case (state_r)
          ST_IDLE: begin
            if (DataIn == 8'hFF) begin
              state_r <= ST_GOTFF;
            end
          end
          ST_GOTFF: begin
            if (DataIn == 8'h00) begin
              state_r <= ST_IDLE;
            end else if (DataIn == 8'hFF) begin
              state_r <= ST_GOTFF;
            end else if (DataIn[7:3] == 5'b11010) begin
              rst_cnt_r <= DataIn[2:0];
              state_r   <= ST_IDLE;
            end else begin
              code_r   <= DataIn;
              marker_r <= 1'b1;
              state_r  <= ST_HOLD;
            end
          end
          default: begin
            state_r <= ST_HOLD;
          end
        endcase
      end
    end
  end

  assign DataInRead    = accept_s;
  assign DataOut       = buf_r[63:32];
  assign DataOutEnable = (cnt_r >= 7'd32) || marker_r;
  assign MarkerDetect  = marker_r;
  assign MarkerCode    = code_r;
  assign RestartCount  = rst_cnt_r;
  assign StreamError   = err_r;

endmodule

// File: tb/tb_aq_djpeg_bitfeed.sv
// Self-checking bench for aq_djpeg_bitfeed. Expected output snapshots are
// queued when a stimulus step is driven and popped/compared once the DUT
// has produced the result of that step.
module tb_aq_djpeg_bitfeed;

  logic        rst;
  logic        clk;
  logic        ProcessInit;
  logic        DataInEnable;
  logic [7:0]  DataIn;
  logic        DataInRead;
  logic        DecodeUseBit;
  logic [6:0]  DecodeUseWidth;
  logic        DecodeAlignByte;
  logic        DataOutEnable;
  logic [31:0] DataOut;
  logic        MarkerDetect;
  logic [7:0]  MarkerCode;
  logic [2:0]  RestartCount;
  logic        StreamError;

  int n_checks;
  int n_fail;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        oen;
    logic        mdet;
    logic [7:0]  code;
    logic [2:0]  rc;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  aq_djpeg_bitfeed dut (
    .rst             (rst),
    .clk             (clk),
    .ProcessInit     (ProcessInit),
    .DataInEnable    (DataInEnable),
    .DataIn          (DataIn),
    .DataInRead      (DataInRead),
    .DecodeUseBit    (DecodeUseBit),
    .DecodeUseWidth  (DecodeUseWidth),
    .DecodeAlignByte (DecodeAlignByte),
    .DataOutEnable   (DataOutEnable),
    .DataOut         (DataOut),
    .MarkerDetect    (MarkerDetect),
    .MarkerCode      (MarkerCode),
    .RestartCount    (RestartCount),
    .StreamError     (StreamError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input string tag, input logic [31:0] data, input logic oen,
                          input logic mdet, input logic [7:0] code, input logic [2:0] rc,
                          input logic err);
    exp_t e;
    e.tag = tag; e.data = data; e.oen = oen; e.mdet = mdet;
    e.code = code; e.rc = rc; e.err = err;
    exp_q.push_back(e);
  endtask

  // pop the oldest expectation and compare against the DUT outputs now
  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, ".data"}, DataOut, e.data);
      check_val({e.tag, ".oen"},  {31'd0, DataOutEnable}, {31'd0, e.oen});
      check_val({e.tag, ".mdet"}, {31'd0, MarkerDetect},  {31'd0, e.mdet});
      check_val({e.tag, ".code"}, {24'd0, MarkerCode},    {24'd0, e.code});
      check_val({e.tag, ".rc"},   {29'd0, RestartCount},  {29'd0, e.rc});
      check_val({e.tag, ".err"},  {31'd0, StreamError},   {31'd0, e.err});
    end
  endtask

  // all tasks start and end at posedge+1
  task automatic send_byte(input logic [7:0] b);
    DataInEnable = 1'b1;
    DataIn       = b;
    #1;
    check_val("accept", {31'd0, DataInRead}, 32'd1);
    @(posedge clk); #1;
    DataInEnable = 1'b0;
  endtask

  task automatic consume(input logic use_bit, input logic [6:0] w, input logic align);
    DecodeUseBit    = use_bit;
    DecodeUseWidth  = w;
    DecodeAlignByte = align;
    @(posedge clk); #1;
    DecodeUseBit    = 1'b0;
    DecodeUseWidth  = 7'd0;
    DecodeAlignByte = 1'b0;
  endtask

  task automatic do_init();
    ProcessInit  = 1'b1;
    DataInEnable = 1'b1;
    DataIn       = 8'h12;
    #1;
    check_val("init_blocks_read", {31'd0, DataInRead}, 32'd0);
    @(posedge clk); #1;
    ProcessInit  = 1'b0;
    DataInEnable = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; ProcessInit = 1'b0; DataInEnable = 1'b0; DataIn = 8'h00;
    DecodeUseBit = 1'b0; DecodeUseWidth = 7'd0; DecodeAlignByte = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_push("reset", 32'h0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    check_out();
    check_val("reset_read", {31'd0, DataInRead}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // fill
    exp_push("fill3", 32'h12345600, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    check_out();
    exp_push("fill4", 32'h12345678, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    send_byte(8'h78);
    check_out();

    // stuffing
    do_init();
    exp_push("stuff", 32'hABFFCDEF, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    send_byte(8'hAB); send_byte(8'hFF); send_byte(8'h00); send_byte(8'hCD); send_byte(8'hEF);
    check_out();
    do_init();
    exp_push("fill_ff", 32'hFF000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    check_out();

    // consume / align / combined
    do_init();
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'h78); send_byte(8'h9A); send_byte(8'hBC);
    exp_push("use4", 32'h23456789, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    consume(1'b1, 7'd4, 1'b0);
    check_out();
    exp_push("align", 32'h3456789A, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    consume(1'b0, 7'd0, 1'b1);
    check_out();
    exp_push("align_noop", 32'h3456789A, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    consume(1'b0, 7'd0, 1'b1);
    check_out();
    // consume 8 and append DE in the same cycle: 40-8+8 = 40 bits
    exp_push("use_and_byte", 32'h56789ABC, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    DecodeUseBit = 1'b1; DecodeUseWidth = 7'd8;
    send_byte(8'hDE);
    DecodeUseBit = 1'b0; DecodeUseWidth = 7'd0;
    check_out();
    exp_push("use32", 32'hDE000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    consume(1'b1, 7'd32, 1'b0);
    check_out();
    // use 3 of DE (8 left) then align drops the remaining 5
    exp_push("use_then_align", 32'h00000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    consume(1'b1, 7'd3, 1'b1);
    check_out();

    // restart marker
    do_init();
    exp_push("rst_marker", 32'h11223344, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0);
    send_byte(8'h11); send_byte(8'hFF); send_byte(8'hD3);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check_out();

    // EOI marker freezes the feed
    do_init();
    exp_push("eoi", 32'hAA000000, 1'b1, 1'b1, 8'hD9, 3'd0, 1'b0);
    send_byte(8'hAA); send_byte(8'hFF); send_byte(8'hD9);
    check_out();
    DataInEnable = 1'b1; DataIn = 8'h55;
    #1;
    check_val("hold_no_read", {31'd0, DataInRead}, 32'd0);
    @(posedge clk); #1;
    DataInEnable = 1'b0;
    exp_push("hold_drain", 32'h00000000, 1'b1, 1'b1, 8'hD9, 3'd0, 1'b0);
    consume(1'b1, 7'd16, 1'b0);
    check_out();

    // pending FF discarded by ProcessInit
    do_init();
    send_byte(8'hFF);
    do_init();
    exp_push("ff_dropped", 32'h41424344, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h44);
    check_out();

    // underflow error
    do_init();
    send_byte(8'h5A);
    exp_push("underflow", 32'h00000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    consume(1'b1, 7'd16, 1'b0);
    check_out();

    // width 0 clamps to 32 and flags
    do_init();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    exp_push("clamp0", 32'h05000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    consume(1'b1, 7'd0, 1'b0);
    check_out();

    // ProcessInit returns everything to reset values
    do_init();
    exp_push("init_clear", 32'h0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
    check_out();

    // width 33 clamps too
    send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hA5); send_byte(8'h5A);
    send_byte(8'h77);
    exp_push("clamp33", 32'h77000000, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
    consume(1'b1, 7'd33, 1'b0);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
